// File: rtl/div_arb_pkg.sv
// Shared types for the divider arbiter: FSM state encoding.
package div_arb_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/stl_reg.sv
// Generic register with async active-low reset and write enable.
// Latency: one cycle from i_en to o_q.
// Backpressure: none; holds value while i_en is low.
module stl_reg #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q <= RST_VAL;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/stl_rr_arb.sv
// Round-robin pick: first valid requester at or after i_ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module stl_rr_arb #(
  parameter int NREQ = 2,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IDXW-1:0] i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDXW-1:0] o_idx,
  output logic            o_any
);

  logic [IDXW-1:0] cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    cand    = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = IDXW'((int'(i_ptr) + off) % NREQ);
      if (!o_any && i_valid[cand]) begin
        o_any         = 1'b1;
        o_grant[cand] = 1'b1;
        o_idx         = cand;
      end
    end
  end

endmodule

// File: rtl/div_arb.sv
// Shares one multi-cycle divider between NREQ requesters, one op in flight, RR grant.
// Latency: accept T, start T+1 if divider idle, response the cycle after divider end handshake.
// Backpressure: requesters stall until IDLE; response held until owner ready or flushed.
module div_arb
  import div_arb_pkg::*;
#(
  parameter int W    = 64,
  parameter int NREQ = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NREQ-1:0]          i_req_valid,
  output logic [NREQ-1:0]          o_req_ready,
  input  logic [NREQ-1:0]          i_req_divw,
  input  logic [NREQ-1:0]          i_req_signed,
  input  logic [NREQ-1:0]          i_req_rem,
  input  logic [NREQ-1:0][W-1:0]   i_req_dividend,
  input  logic [NREQ-1:0][W-1:0]   i_req_divisor,
  input  logic [NREQ-1:0]          i_flush,
  output logic [NREQ-1:0]          o_rsp_valid,
  input  logic [NREQ-1:0]          i_rsp_ready,
  output logic [W-1:0]             o_rsp_res,
  output logic                     o_div_start,
  input  logic                     i_div_busy,
  output logic                     o_div_divw,
  output logic                     o_div_signed,
  output logic [W-1:0]             o_div_dividend,
  output logic [W-1:0]             o_div_divisor,
  input  logic                     i_div_end_valid,
  output logic                     o_div_end_ready,
  input  logic [W-1:0]             i_div_quotient,
  input  logic [W-1:0]             i_div_remainder
);

  localparam int IDXW = $clog2(NREQ);

  state_t          state;
  logic            kill;
  logic [NREQ-1:0] grant_oh;
  logic [IDXW-1:0] grant_idx;
  logic            grant_any;
  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] rr_next;
  logic [IDXW-1:0] owner;
  logic [2:0]      ctrl_d;
  logic [2:0]      ctrl_q;
  logic [W-1:0]    res_d;
  logic [W-1:0]    res_q;
  logic            hs;
  logic            own_flush;
  logic            own_rsp_rdy;
  logic            capture;
  logic            res_en;

  stl_rr_arb #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
    .i_valid (i_req_valid),
    .i_ptr   (rr_ptr),
    .o_grant (grant_oh),
    .o_idx   (grant_idx),
    .o_any   (grant_any)
  );

  assign hs          = (state == S_IDLE) && grant_any;
  assign o_req_ready = (state == S_IDLE) ? grant_oh : '0;
  assign rr_next     = (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + IDXW'(1);
  assign ctrl_d      = {i_req_divw[grant_idx], i_req_signed[grant_idx], i_req_rem[grant_idx]};

  stl_reg #(.W(IDXW)) u_rr_ptr (
    .i_clk, .i_rst_n, .i_en(hs), .i_d(rr_next), .o_q(rr_ptr)
  );
  stl_reg #(.W(IDXW)) u_owner (
    .i_clk, .i_rst_n, .i_en(hs), .i_d(grant_idx), .o_q(owner)
  );
  stl_reg #(.W(3)) u_ctrl (
    .i_clk, .i_rst_n, .i_en(hs), .i_d(ctrl_d), .o_q(ctrl_q)
  );
  stl_reg #(.W(W)) u_dividend (
    .i_clk, .i_rst_n, .i_en(hs), .i_d(i_req_dividend[grant_idx]), .o_q(o_div_dividend)
  );
  stl_reg #(.W(W)) u_divisor (
    .i_clk, .i_rst_n, .i_en(hs), .i_d(i_req_divisor[grant_idx]), .o_q(o_div_divisor)
  );

  assign o_div_divw   = ctrl_q[2];
  assign o_div_signed = ctrl_q[1];

  assign own_flush   = i_flush[owner];
  assign own_rsp_rdy = i_rsp_ready[owner];

  // A killed or same-cycle-flushed op still drains the divider but never reaches the result reg.
  assign capture = (state == S_WAIT) && i_div_end_valid;
  assign res_en  = capture && !kill && !own_flush;
  assign res_d   = ctrl_q[0] ? i_div_remainder : i_div_quotient;

  stl_reg #(.W(W)) u_result (
    .i_clk, .i_rst_n, .i_en(res_en), .i_d(res_d), .o_q(res_q)
  );

  assign o_div_start     = (state == S_ISSUE) && !i_div_busy && !own_flush;
  assign o_div_end_ready = (state == S_WAIT);
  assign o_rsp_valid     = (state == S_RESP) ? (NREQ'(1) << owner) : '0;
  assign o_rsp_res       = (state == S_RESP) ? res_q : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      kill  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          kill <= 1'b0;
          if (hs) state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (own_flush) state <= S_IDLE;
          else if (!i_div_busy) state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_div_end_valid) begin
            kill  <= 1'b0;
            state <= (kill || own_flush) ? S_IDLE : S_RESP;
          end else if (own_flush) begin
            kill <= 1'b1;
          end
        end
        S_RESP: begin
          if (own_flush || own_rsp_rdy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arb.sv
// Directed bench for div_arb with a behavioural stand-in for the divider core.
module tb_div_arb;

  localparam int W    = 64;
  localparam int NREQ = 2;
  localparam logic [W-1:0] ONES = '1;

  typedef logic [0:0] rid_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]        req_valid, req_ready, req_divw, req_signed, req_rem;
  logic [NREQ-1:0]        flush, rsp_valid, rsp_ready;
  logic [NREQ-1:0][W-1:0] req_dividend, req_divisor;
  logic [W-1:0]           rsp_res, div_dividend, div_divisor, div_q, div_r;
  logic                   div_start, div_divw, div_signed, div_end_ready;
  logic                   div_busy, force_busy, m_busy, m_end;

  assign div_busy = force_busy | m_busy;

  div_arb #(.W(W), .NREQ(NREQ)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_divw      (req_divw),
    .i_req_signed    (req_signed),
    .i_req_rem       (req_rem),
    .i_req_dividend  (req_dividend),
    .i_req_divisor   (req_divisor),
    .i_flush         (flush),
    .o_rsp_valid     (rsp_valid),
    .i_rsp_ready     (rsp_ready),
    .o_rsp_res       (rsp_res),
    .o_div_start     (div_start),
    .i_div_busy      (div_busy),
    .o_div_divw      (div_divw),
    .o_div_signed    (div_signed),
    .o_div_dividend  (div_dividend),
    .o_div_divisor   (div_divisor),
    .i_div_end_valid (m_end),
    .o_div_end_ready (div_end_ready),
    .i_div_quotient  (div_q),
    .i_div_remainder (div_r)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Divider stand-in: result words nq/nr are supplied by the test, DIV_LAT cycles after start.
  localparam int DIV_LAT = 3;
  logic [W-1:0] nq, nr, cap_dividend, cap_divisor;
  logic [1:0]   cap_ctrl;
  logic         ts, te;
  int           cnt, n_starts;

  initial begin
    m_busy = 1'b0; m_end = 1'b0; div_q = '0; div_r = '0;
    cnt = 0; n_starts = 0; cap_dividend = '0; cap_divisor = '0; cap_ctrl = '0;
    forever begin
      @(negedge clk);
      ts = div_start && !div_busy;
      te = m_end && div_end_ready;
      if (ts) begin
        cap_dividend = div_dividend;
        cap_divisor  = div_divisor;
        cap_ctrl     = {div_divw, div_signed};
      end
      @(posedge clk); #1;
      if (!rst_n) begin
        m_busy = 1'b0; m_end = 1'b0;
      end else begin
        if (te) begin
          m_end = 1'b0; m_busy = 1'b0;
        end else if (m_busy && !m_end) begin
          if (cnt <= 1) begin
            m_end = 1'b1; div_q = nq; div_r = nr;
          end else begin
            cnt--;
          end
        end
        if (ts) begin
          m_busy = 1'b1; cnt = DIV_LAT; n_starts++;
        end
      end
    end
  end

  task automatic set_op(input rid_t r, input logic dw, input logic sg, input logic rm,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    req_divw[r] = dw; req_signed[r] = sg; req_rem[r] = rm;
    req_dividend[r] = a; req_divisor[r] = b; req_valid[r] = 1'b1;
  endtask

  task automatic wait_grant(input rid_t r, input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (req_ready == '0 && k < 40) begin @(negedge clk); k++; end
    chk({nm, " ready"}, W'(req_ready), W'(NREQ'(1) << r));
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(input rid_t r, input logic [W-1:0] exp, input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (rsp_valid == '0 && k < 60) begin @(negedge clk); k++; end
    chk({nm, " rsp_valid"}, W'(rsp_valid), W'(NREQ'(1) << r));
    chk({nm, " res"}, rsp_res, exp);
  endtask

  typedef struct {
    rid_t         r;
    logic         dw, sg, rm;
    logic [W-1:0] a, b, q, rr, exp;
  } vec_t;

  vec_t tbl [6];
  int   s0;
  logic seen_end, bad;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 64'd1000, 64'd10, 64'd100, 64'd0, 64'd100};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 64'd100, 64'd7, 64'd14, 64'd2, 64'd2};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,
               64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, ONES, ONES};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 64'd5, 64'd0, ONES, 64'd5, ONES};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h1_0000_0010, 64'd4, 64'd4, 64'd0, 64'd4};

    req_valid = '0; req_divw = '0; req_signed = '0; req_rem = '0;
    req_dividend = '0; req_divisor = '0; flush = '0; rsp_ready = '1;
    force_busy = 1'b0; nq = '0; nr = '0;

    // Reset state
    @(negedge clk);
    chk("rst req_ready", W'(req_ready), 0);
    chk("rst rsp_valid", W'(rsp_valid), 0);
    chk("rst rsp_res", rsp_res, 0);
    chk("rst start/end_ready", W'({div_start, div_end_ready, div_divw, div_signed}), 0);
    chk("rst dividend", div_dividend, 0);
    chk("rst divisor", div_divisor, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // DIVU 100/7 on requester 0 with exact latency
    @(posedge clk); #1;
    nq = 64'd14; nr = 64'd2;
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 64'd100, 64'd7);
    @(negedge clk);
    chk("t1 ready", W'(req_ready), 64'd1);
    chk("t1 start in accept cycle", W'(div_start), 0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1 start next cycle", W'(div_start), 1);
    chk("t1 div dividend", div_dividend, 64'd100);
    chk("t1 div divisor", div_divisor, 64'd7);
    chk("t1 ready while busy", W'(req_ready), 0);
    begin
      int k;
      k = 0;
      while (!(m_end && div_end_ready) && k < 20) begin @(negedge clk); k++; end
    end
    chk("t1 end handshake", W'(m_end && div_end_ready), 1);
    @(negedge clk);
    chk("t1 rsp_valid E+1", W'(rsp_valid), 64'd1);
    chk("t1 res", rsp_res, 64'd14);
    @(negedge clk);
    chk("t1 rsp_valid cleared", W'(rsp_valid), 0);
    chk("t1 res zero outside RESP", rsp_res, 0);

    // Table of single-requester ops
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      nq = tbl[i].q; nr = tbl[i].rr;
      s0 = n_starts;
      set_op(tbl[i].r, tbl[i].dw, tbl[i].sg, tbl[i].rm, tbl[i].a, tbl[i].b);
      wait_grant(tbl[i].r, $sformatf("vec%0d", i));
      wait_rsp(tbl[i].r, tbl[i].exp, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d dividend", i), cap_dividend, tbl[i].a);
      chk($sformatf("vec%0d divisor", i), cap_divisor, tbl[i].b);
      chk($sformatf("vec%0d divw/signed", i), W'(cap_ctrl), W'({tbl[i].dw, tbl[i].sg}));
      chk($sformatf("vec%0d starts", i), W'(n_starts - s0), 1);
    end

    // Simultaneous REMW -7/2: pointer at 0 serves req0 then req1
    @(posedge clk); #1;
    nq = 64'hFFFF_FFFF_FFFF_FFFD; nr = ONES;
    set_op(1'b0, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    set_op(1'b1, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    wait_grant(1'b0, "pair0 first");
    wait_rsp(1'b0, ONES, "pair0 first");
    chk("pair0 loser not ready", W'(req_ready), 0);
    wait_grant(1'b1, "pair0 second");
    wait_rsp(1'b1, ONES, "pair0 second");
    // One req0 op moves the pointer to 1, so the next pair goes to req1 first
    @(posedge clk); #1;
    set_op(1'b0, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    wait_grant(1'b0, "solo0");
    wait_rsp(1'b0, ONES, "solo0");
    @(posedge clk); #1;
    set_op(1'b0, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    set_op(1'b1, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    wait_grant(1'b1, "pair1 first");
    wait_rsp(1'b1, ONES, "pair1 first");
    wait_grant(1'b0, "pair1 second");
    wait_rsp(1'b0, ONES, "pair1 second");

    // Divider busy for 3 cycles in ISSUE
    @(posedge clk); #1;
    nq = 64'd14; nr = 64'd2;
    force_busy = 1'b1;
    s0 = n_starts;
    set_op(1'b0, 1'b0, 1'b0, 1'b1, 64'd100, 64'd7);
    wait_grant(1'b0, "busy");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("busy start low %0d", i), W'(div_start), 0);
      @(posedge clk); #1;
    end
    force_busy = 1'b0;
    @(negedge clk);
    chk("busy start after release", W'(div_start), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy single pulse", W'(div_start), 0);
    chk("busy start count", W'(n_starts - s0), 1);
    wait_rsp(1'b0, 64'd2, "busy");

    // Owner flush during WAIT: op drains, no response
    @(posedge clk); #1;
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 64'd100, 64'd7);
    wait_grant(1'b1, "flwait");
    @(negedge clk);
    chk("flwait start", W'(div_start), 1);
    @(posedge clk); #1;
    flush[1] = 1'b1;
    @(posedge clk); #1;
    flush[1] = 1'b0;
    seen_end = 1'b0; bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_end && div_end_ready) seen_end = 1'b1;
      if (rsp_valid != '0) bad = 1'b1;
    end
    chk("flwait divider drained", W'(seen_end), 1);
    chk("flwait no rsp", W'(bad), 0);

    // Flush of a non-owner during WAIT has no effect
    @(posedge clk); #1;
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 64'd100, 64'd7);
    wait_grant(1'b0, "nonowner");
    @(negedge clk);
    @(posedge clk); #1;
    flush[1] = 1'b1;
    @(posedge clk); #1;
    flush[1] = 1'b0;
    wait_rsp(1'b0, 64'd14, "nonowner");

    // Owner flush in ISSUE: no start issued, back to IDLE
    @(posedge clk); #1;
    force_busy = 1'b1;
    s0 = n_starts;
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 64'd100, 64'd7);
    @(negedge clk);
    chk("flissue ready", W'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    flush[0] = 1'b1;
    force_busy = 1'b0;
    @(negedge clk);
    chk("flissue start suppressed", W'(div_start), 0);
    @(posedge clk); #1;
    flush[0] = 1'b0;
    @(negedge clk);
    chk("flissue idle end_ready", W'(div_end_ready), 0);
    chk("flissue no start", W'(n_starts - s0), 0);

    // Owner (req1, pointer at 1) stalls rsp_ready 5 cycles while req0 waits
    @(posedge clk); #1;
    rsp_ready = '0;
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 64'd100, 64'd7);
    set_op(1'b1, 1'b0, 1'b0, 1'b1, 64'd100, 64'd7);
    wait_grant(1'b1, "stall");
    wait_rsp(1'b1, 64'd2, "stall");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("stall rsp_valid %0d", i), W'(rsp_valid), 64'd2);
      chk($sformatf("stall res %0d", i), rsp_res, 64'd2);
      chk($sformatf("stall other ready %0d", i), W'(req_ready), 0);
    end
    @(posedge clk); #1;
    rsp_ready[1] = 1'b1;
    wait_grant(1'b0, "after stall");
    wait_rsp(1'b0, 64'd14, "after stall");
    // Flush in RESP: response still shown that cycle, gone the next
    @(posedge clk); #1;
    flush[0] = 1'b1;
    @(negedge clk);
    chk("flresp still shown", W'(rsp_valid), 64'd1);
    @(posedge clk); #1;
    flush[0] = 1'b0;
    @(negedge clk);
    chk("flresp dropped", W'(rsp_valid), 0);
    rsp_ready = '1;

    // Async reset mid-WAIT
    @(posedge clk); #1;
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 64'd100, 64'd7);
    wait_grant(1'b1, "rstmid");
    @(negedge clk);
    @(posedge clk); #1;
    chk("rstmid in WAIT", W'(div_end_ready), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid end_ready", W'(div_end_ready), 0);
    chk("rstmid start/rsp", W'({div_start, rsp_valid, req_ready}), 0);
    chk("rstmid dividend", div_dividend, 0);
    chk("rstmid divisor", div_divisor, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid != '0 || div_end_ready) bad = 1'b1;
    end
    chk("rstmid no response", W'(bad), 0);
    @(posedge clk); #1;
    nq = 64'd14; nr = 64'd2;
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 64'd100, 64'd7);
    wait_grant(1'b0, "post reset");
    wait_rsp(1'b0, 64'd14, "post reset");

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
